// File: rtl/calc_key_pkg.sv
// calc_key_pkg: shared constants, key indices and slot-state encoding for the key front end
package calc_key_pkg;
  localparam int N_KEYS_DEF = 4;
  localparam int KEY_ADD = 0;
  localparam int KEY_SUB = 1;
  localparam int KEY_EQ  = 2;
  localparam int KEY_CLR = 3;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  // never returns less than 1 so the result can always size a bus
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/key_debounce_edge.sv
// key_debounce_edge: two-flop synchroniser, stable-count debouncer and release-edge pulse
module key_debounce_edge
  import calc_key_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  localparam int CNT_W = clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic rel_pulse
);
  logic s1_q, s2_q, deb_q, deb_d, diff, hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    diff = s2_q != deb_q;
    hit = diff && (cnt_q == CNT_W'(DEB_CYCLES - 1));
    cnt_d = (!diff || hit) ? '0 : cnt_q + CNT_W'(1);
    deb_d = hit ? ~deb_q : deb_q;
  end
  // fires in the cycle the debounced level is about to fall, so pending sets on that same edge
  assign rel_pulse = hit & deb_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: per-key release detection serialised onto one valid/ready port, round-robin
module key_event_scheduler
  import calc_key_pkg::*;
#(
  parameter int N_KEYS = N_KEYS_DEF,
  parameter int DEB_CYCLES = 16,
  localparam int CODE_W = clog2(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic              ovf,
  input  logic              ovf_clr
);
  logic [N_KEYS-1:0] rel, pend_q, pend_d, gmask;
  logic [CODE_W-1:0] rr_q, rr_d, code_q, code_d, gidx, jj;
  logic [0:0] st_q, st_d;
  logic ovf_q, ovf_d, found, take, grant, drop;
  int j;
  genvar i;
  for (i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_key (
      .clk(clk),
      .rst(rst),
      .key_raw(keys[i]),
      .rel_pulse(rel[i])
    );
  end
  // first pending key at or after rr_q, wrapping explicitly so non-power-of-two counts work
  always_comb begin
    found = 1'b0;
    gidx = '0;
    j = 0;
    jj = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_KEYS) j = j - N_KEYS;
      jj = CODE_W'(j);
      if (!found && pend_q[jj]) begin
        found = 1'b1;
        gidx = jj;
      end
    end
  end
  always_comb begin
    take = (st_q == ST_IDLE) | evt_ready;
    grant = take & found;
    gmask = grant ? (N_KEYS'(1) << gidx) : '0;
    pend_d = (pend_q & ~gmask) | rel;
    drop = |(rel & pend_q & ~gmask);
    ovf_d = drop | (ovf_q & ~ovf_clr);
    st_d = grant ? ST_HOLD : take ? ST_IDLE : st_q;
    code_d = grant ? gidx : code_q;
    rr_d = !grant ? rr_q : (gidx == CODE_W'(N_KEYS - 1)) ? '0 : gidx + CODE_W'(1);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend_q <= '0;
      rr_q <= '0;
      code_q <= '0;
      st_q <= ST_IDLE;
      ovf_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      rr_q <= rr_d;
      code_q <= code_d;
      st_q <= st_d;
      ovf_q <= ovf_d;
    end
  assign evt_valid = st_q == ST_HOLD;
  assign evt_code = code_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_key_event_scheduler.sv
// tb_key_event_scheduler: directed stimulus with a code scoreboard checked at every handshake
module tb_key_event_scheduler;
  import calc_key_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic evt_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [3:0] keys = 4'b0;
  logic evt_valid, ovf;
  logic [1:0] evt_code;
  int checks = 0;
  int errors = 0;
  int q[$];
  int lat;

  always #5 clk = ~clk;

  key_event_scheduler #(.N_KEYS(4), .DEB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .keys(keys),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ready(evt_ready),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] m);
    keys = keys | m;
    step(10);
    keys = keys & ~m;
    step(10);
  endtask

  always @(negedge clk)
    if (rst && evt_valid && evt_ready) begin
      if (q.size() == 0) chk("evt_unexpected", 32'(q.size()), 32'd1);
      else chk("evt_code", 32'(evt_code), 32'(q.pop_front()));
    end

  initial begin
    step(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step(1);
      chk("idle_valid", 32'(evt_valid), 32'd0);
      chk("idle_ovf", 32'(ovf), 32'd0);
    end
    evt_ready = 1'b1;
    q.push_back(KEY_EQ);
    keys[KEY_EQ] = 1'b1;
    step(20);
    keys[KEY_EQ] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      step(1);
      if (evt_valid) lat = c;
    end
    chk("t2_latency", 32'(lat), 32'd7);
    chk("t2_code", 32'(evt_code), 32'(KEY_EQ));
    step(1);
    chk("t2_single_pulse", 32'(evt_valid), 32'd0);
    step(10);
    chk("t2_sb_empty", 32'(q.size()), 32'd0);
    q.push_back(KEY_SUB);
    for (int c = 0; c < 10; c++) begin
      keys[KEY_SUB] = ~keys[KEY_SUB];
      step(2);
    end
    keys[KEY_SUB] = 1'b1;
    step(10);
    keys[KEY_SUB] = 1'b0;
    step(15);
    chk("t3_sb_empty", 32'(q.size()), 32'd0);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    evt_ready = 1'b0;
    step(1);
    keys = 4'b1011;
    step(10);
    keys = 4'b0000;
    step(12);
    chk("t4_hold_valid", 32'(evt_valid), 32'd1);
    chk("t4_hold_code", 32'(evt_code), 32'(KEY_ADD));
    step(8);
    chk("t4_hold_stable", 32'(evt_code), 32'(KEY_ADD));
    q.push_back(KEY_ADD);
    q.push_back(KEY_SUB);
    q.push_back(KEY_CLR);
    evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_b2b_valid", 32'(evt_valid), 32'd1);
      step(1);
    end
    chk("t4_b2b_end", 32'(evt_valid), 32'd0);
    chk("t4_sb_empty", 32'(q.size()), 32'd0);
    q.push_back(KEY_ADD);
    q.push_back(KEY_CLR);
    keys = 4'b1001;
    step(10);
    keys = 4'b0000;
    step(12);
    chk("t4_wrap_done", 32'(evt_valid), 32'd0);
    chk("t4_wrap_sb_empty", 32'(q.size()), 32'd0);
    evt_ready = 1'b0;
    q.push_back(KEY_ADD);
    tap(4'b0001);
    chk("t5_hold_valid", 32'(evt_valid), 32'd1);
    chk("t5_hold_code", 32'(evt_code), 32'(KEY_ADD));
    q.push_back(KEY_EQ);
    tap(4'b0100);
    chk("t5_no_ovf_first", 32'(ovf), 32'd0);
    tap(4'b0100);
    chk("t5_ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(ovf), 32'd0);
    evt_ready = 1'b1;
    step(5);
    chk("t5_drained", 32'(evt_valid), 32'd0);
    chk("t5_sb_empty", 32'(q.size()), 32'd0);
    evt_ready = 1'b0;
    tap(4'b1000);
    chk("t6_hold_valid", 32'(evt_valid), 32'd1);
    chk("t6_hold_code", 32'(evt_code), 32'(KEY_CLR));
    tap(4'b0010);
    tap(4'b0010);
    chk("t6_ovf_set", 32'(ovf), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(evt_valid), 32'd0);
    chk("t6_async_code", 32'(evt_code), 32'd0);
    chk("t6_async_ovf", 32'(ovf), 32'd0);
    step(2);
    rst = 1'b1;
    evt_ready = 1'b1;
    step(40);
    chk("t6_no_stale_evt", 32'(evt_valid), 32'd0);
    chk("t6_sb_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
